// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Owns the architectural fetch PC and runs the instruction-memory handshake
//   for the single-issue core. Only one imem request is ever outstanding, and
//   the fetched word is handed to decode through a valid/ready register stage.
//   Redirects retarget the PC. A redirect that lands while a request is in
//   flight marks that request as killed, so its response is thrown away. A
//   misaligned redirect target parks the sequencer in FAULT until reset.
//
// Ports
//   clk, reset_n                      clock, asynchronous active-low reset
//   imem_req_valid/ready/addr         fetch request channel (addr == pc)
//   imem_rsp_valid/data               fetch response, one per accepted request
//   inst_valid/ready/data/pc          instruction handed to decode
//   redirect_valid/target             control-flow redirect (1-cycle pulse)
//   halt                              level, blocks new fetches when entering REQ
//   pc                                current fetch PC
//   misalign_fault                    sticky, redirect target not word aligned
//
// Optional build macro
//   FETCH_SEQUENCER_PERF_EN           adds saturating perf_fetch_count and
//                                     perf_kill_count outputs
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned PC_STEP      = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt,
  output logic [31:0] pc,
  output logic        misalign_fault
`ifdef FETCH_SEQUENCER_PERF_EN
  ,
  output logic [31:0] perf_fetch_count,
  output logic [31:0] perf_kill_count
`endif
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic        kill, kill_nxt;
  logic        capture;
  logic        redirect_ok;
  logic        redirect_bad;

  assign redirect_ok  = redirect_valid && (redirect_target[1:0] == 2'b00);
  assign redirect_bad = redirect_valid && (redirect_target[1:0] != 2'b00);

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and next-datapath logic
  always_comb begin
    // NOTE: every target gets a default first, so no path through the
    // case statement can leave a value unassigned and infer a latch.
    state_nxt = state;
    pc_nxt    = pc;
    kill_nxt  = kill;
    capture   = 1'b0;

    unique case (state)
      IDLE: begin
        if (redirect_ok) pc_nxt = redirect_target;
        if (!halt)       state_nxt = REQ;
      end
      REQ: begin
        // The address may only move before acceptance, and only because of a redirect.
        if (redirect_ok) pc_nxt = redirect_target;
        if (imem_req_ready) begin
          state_nxt = WAIT;
          kill_nxt  = redirect_ok;
        end
      end
      WAIT: begin
        if (redirect_ok) pc_nxt = redirect_target;
        if (imem_rsp_valid) begin
          if (kill || redirect_valid) begin
            kill_nxt  = 1'b0;
            state_nxt = halt ? IDLE : REQ;
          end else begin
            capture   = 1'b1;
            pc_nxt    = pc + 32'(PC_STEP);
            state_nxt = HOLD;
          end
        end else if (redirect_ok) begin
          kill_nxt = 1'b1;
        end
      end
      HOLD: begin
        // A redirect takes priority over a handshake in the same cycle.
        if (redirect_ok) begin
          pc_nxt    = redirect_target;
          state_nxt = halt ? IDLE : REQ;
        end else if (inst_ready) begin
          state_nxt = halt ? IDLE : REQ;
        end
      end
      FAULT: ;
      default: state_nxt = IDLE;
    endcase

    // A bad target overrides everything else. The PC keeps its old value, and
    // any response still in flight is absorbed silently in FAULT.
    if (redirect_bad && state != FAULT) begin
      state_nxt = FAULT;
      pc_nxt    = pc;
      kill_nxt  = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= RESET_VECTOR;
      kill      <= 1'b0;
      inst_data <= 32'h0;
      inst_pc   <= 32'h0;
    end else begin
      pc   <= pc_nxt;
      kill <= kill_nxt;
      if (capture) begin
        inst_data <= imem_rsp_data;
        inst_pc   <= pc;
      end
    end
  end

  // Outputs decoded from the state
  always_comb begin
    imem_req_valid = (state == REQ);
    imem_req_addr  = pc;
    inst_valid     = (state == HOLD);
    misalign_fault = (state == FAULT);
  end

`ifdef FETCH_SEQUENCER_PERF_EN
  logic fetch_evt;
  logic kill_evt;

  assign fetch_evt = (state == HOLD) && inst_ready && !redirect_valid;
  assign kill_evt  = ((state == WAIT) && imem_rsp_valid && (kill || redirect_valid)) ||
                     ((state == HOLD) && redirect_valid);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetch_count <= 32'h0;
      perf_kill_count  <= 32'h0;
    end else begin
      if (fetch_evt && perf_fetch_count != 32'hFFFF_FFFF)
        perf_fetch_count <= perf_fetch_count + 32'd1;
      if (kill_evt && perf_kill_count != 32'hFFFF_FFFF)
        perf_kill_count <= perf_kill_count + 32'd1;
    end
  end
`else
  // The base build carries no performance counters.
`endif

endmodule
